// File: rtl/trigger_coinc_pkg.sv
// trigger_coinc_pkg: FSM encoding and record layout shared by the trigger
// coincidence master and its record FIFO.
package trigger_coinc_pkg;
   typedef enum logic [1:0] {IDLE, TRIG, WAIT_BUSY, WAIT_RELEASE} state_t;
   localparam int REC_WORDS = 4;
   localparam int WIDX_W = $clog2(REC_WORDS);
   localparam int REC_W = 56;
   localparam logic [7:0] REC_MARKER = 8'hA5;
endpackage

// File: rtl/trig_record_fifo.sv
// trig_record_fifo: synchronous record FIFO with first-word fall-through read
// data; a write while full succeeds when a pop happens in the same cycle.
module trig_record_fifo
   import trigger_coinc_pkg::*;
#(
   parameter int W     = REC_W,
   parameter int DEPTH = 16
) (
   input  logic         BUS_CLK,
   input  logic         RST,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0] cnt_q;
   logic do_wr, do_rd;
   assign empty_o = cnt_q == '0;
   assign full_o = cnt_q == (AW+1)'(DEPTH);
   assign do_rd = rd_en_i && !empty_o;
   assign do_wr = wr_en_i && (!full_o || do_rd);
   assign rd_data_o = mem_q[rd_ptr_q];
   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(do_wr);
         rd_ptr_q <= rd_ptr_q + AW'(do_rd);
         cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end
   always_ff @(posedge BUS_CLK) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end
endmodule

// File: rtl/trigger_coinc_master.sv
// trigger_coinc_master: windowed AND/OR coincidence trigger with DUT busy
// handshake, statistics counters and a 4-word-per-record readout FIFO.
module trigger_coinc_master
   import trigger_coinc_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int TRIG_ID_W = 16,
   parameter int DEPTH     = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [N_CH-1:0]      CH_IN,
   input  logic [N_CH-1:0]      CONF_EN,
   input  logic [N_CH-1:0]      CONF_INV,
   input  logic                 CONF_MODE,
   input  logic [4:0]           CONF_WINDOW,
   input  logic [15:0]          CONF_TIMEOUT,
   input  logic                 TEST_PULSE,
   input  logic                 DUT_BUSY,
   output logic                 DUT_TRIGGER,
   input  logic                 FIFO_READ,
   output logic                 FIFO_EMPTY,
   output logic [15:0]          FIFO_DATA,
   output logic [TRIG_ID_W-1:0] TRIG_ID,
   output logic [31:0]          SKIP_CNT,
   output logic [7:0]           TIMEOUT_CNT,
   output logic [7:0]           LOST_CNT
);
   logic [N_CH-1:0] ch_s1_q, ch_s2_q, lvl_q, seen_q, seen_d, lvl, edge_v, armed, en_armed;
   logic [N_CH-1:0][4:0] age_q, age_d;
   logic busy_s1_q, busy_s2_q, src_q, dut_trig_q;
   logic coinc, src, trig_req, accept, skip, in_wait, tmo_hit;
   state_t state_q, state_d;
   logic [15:0] wait_q, wait_d;
   logic [TRIG_ID_W-1:0] trig_id_q, trig_id_d;
   logic [31:0] skip_q, skip_d, ts_q, ts_d;
   logic [7:0] tmo_q, tmo_d, lost_q, lost_d;
   logic [WIDX_W-1:0] widx_q, widx_d;
   logic [REC_W-1:0] rec_wr, rec_rd;
   logic rec_full, rec_empty, rd_step, pop, lost;
   assign lvl = ch_s2_q ^ CONF_INV;
   assign edge_v = lvl & ~lvl_q;
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         age_d[i] = edge_v[i] ? 5'd0 : age_q[i] + 5'(age_q[i] != 5'd31);
         armed[i] = seen_q[i] && age_q[i] <= CONF_WINDOW;
      end
   end
   assign en_armed = armed & CONF_EN;
   assign coinc = CONF_MODE ? |en_armed : (CONF_EN != '0 && en_armed == CONF_EN);
   assign src = coinc | TEST_PULSE;
   assign trig_req = src && !src_q;
   // a trigger request consumes every armed channel, accepted or not
   assign seen_d = trig_req ? '0 : seen_q | edge_v;
   assign accept = trig_req && state_q == IDLE;
   assign skip = trig_req && state_q != IDLE;
   assign in_wait = state_q == WAIT_BUSY || state_q == WAIT_RELEASE;
   assign tmo_hit = in_wait && CONF_TIMEOUT != 16'd0 && wait_q == CONF_TIMEOUT - 16'd1;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = trig_req ? TRIG : IDLE;
         TRIG:      state_d = WAIT_BUSY;
         WAIT_BUSY: state_d = busy_s2_q ? WAIT_RELEASE : WAIT_BUSY;
         default:   state_d = busy_s2_q ? WAIT_RELEASE : IDLE;
      endcase
      if (tmo_hit) state_d = IDLE;
   end
   assign rd_step = FIFO_READ && !FIFO_EMPTY;
   assign pop = rd_step && widx_q == WIDX_W'(REC_WORDS - 1);
   assign lost = accept && rec_full && !pop;
   always_comb begin
      wait_d = in_wait ? wait_q + 16'd1 : 16'd0;
      trig_id_d = START ? '0 : trig_id_q + TRIG_ID_W'(accept);
      skip_d = START ? '0 : skip_q + 32'(skip);
      tmo_d = START ? '0 : tmo_q + 8'(tmo_hit && tmo_q != 8'hFF);
      ts_d = START ? 32'd1 : ts_q + 32'(ts_q != 32'hFFFF_FFFF);
      lost_d = lost_q + 8'(lost && lost_q != 8'hFF);
      widx_d = widx_q + WIDX_W'(rd_step);
   end
   always_ff @(posedge BUS_CLK) begin
      if (RST) begin
         ch_s1_q <= '0;
         ch_s2_q <= '0;
         lvl_q <= '0;
         seen_q <= '0;
         age_q <= '1;
         busy_s1_q <= 1'b0;
         busy_s2_q <= 1'b0;
         src_q <= 1'b0;
         state_q <= IDLE;
         dut_trig_q <= 1'b0;
         wait_q <= '0;
         trig_id_q <= '0;
         skip_q <= '0;
         tmo_q <= '0;
         lost_q <= '0;
         ts_q <= 32'd1;
         widx_q <= '0;
      end else begin
         ch_s1_q <= CH_IN;
         ch_s2_q <= ch_s1_q;
         lvl_q <= lvl;
         seen_q <= seen_d;
         age_q <= age_d;
         busy_s1_q <= DUT_BUSY;
         busy_s2_q <= busy_s1_q;
         src_q <= src;
         state_q <= state_d;
         dut_trig_q <= accept;
         wait_q <= wait_d;
         trig_id_q <= trig_id_d;
         skip_q <= skip_d;
         tmo_q <= tmo_d;
         lost_q <= lost_d;
         ts_q <= ts_d;
         widx_q <= widx_d;
      end
   end
   assign rec_wr = {16'(trig_id_q), ts_q, 8'(armed)};
   trig_record_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .BUS_CLK   (BUS_CLK),
      .RST       (RST),
      .wr_en_i   (accept),
      .wr_data_i (rec_wr),
      .rd_en_i   (pop),
      .rd_data_o (rec_rd),
      .full_o    (rec_full),
      .empty_o   (rec_empty)
   );
   // record layout {id[55:40], ts[39:8], mask[7:0]}
   assign FIFO_DATA = widx_q == WIDX_W'(0) ? rec_rd[55:40] :
                      widx_q == WIDX_W'(1) ? rec_rd[23:8] :
                      widx_q == WIDX_W'(2) ? rec_rd[39:24] : {rec_rd[7:0], REC_MARKER};
   assign FIFO_EMPTY = widx_q == '0 && rec_empty;
   assign DUT_TRIGGER = dut_trig_q;
   assign TRIG_ID = trig_id_q;
   assign SKIP_CNT = skip_q;
   assign TIMEOUT_CNT = tmo_q;
   assign LOST_CNT = lost_q;
endmodule

// File: tb/tb_trigger_coinc_master.sv
// tb_trigger_coinc_master: directed stimulus; expected readout words are queued
// at stimulus time and a separate monitor pops and compares them on readout.
module tb_trigger_coinc_master;
   localparam int N_CH = 4;
   localparam int TID_W = 16;
   localparam int DEPTH = 8;
   logic BUS_CLK = 1'b0;
   logic RST, START, CONF_MODE, TEST_PULSE, DUT_BUSY, DUT_TRIGGER, FIFO_READ, FIFO_EMPTY;
   logic [N_CH-1:0] CH_IN, CONF_EN, CONF_INV;
   logic [4:0] CONF_WINDOW;
   logic [15:0] CONF_TIMEOUT, FIFO_DATA;
   logic [TID_W-1:0] TRIG_ID;
   logic [31:0] SKIP_CNT;
   logic [7:0] TIMEOUT_CNT, LOST_CNT;
   logic [15:0] exp_q [$];
   int total = 0, bad = 0, rd_req = 0, rd_done = 0, trig_seen = 0, cyc = 0, s_cyc = 0;

   trigger_coinc_master #(.N_CH(N_CH), .TRIG_ID_W(TID_W), .DEPTH(DEPTH)) dut (
      .BUS_CLK(BUS_CLK), .RST(RST), .START(START), .CH_IN(CH_IN), .CONF_EN(CONF_EN),
      .CONF_INV(CONF_INV), .CONF_MODE(CONF_MODE), .CONF_WINDOW(CONF_WINDOW),
      .CONF_TIMEOUT(CONF_TIMEOUT), .TEST_PULSE(TEST_PULSE), .DUT_BUSY(DUT_BUSY),
      .DUT_TRIGGER(DUT_TRIGGER), .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY),
      .FIFO_DATA(FIFO_DATA), .TRIG_ID(TRIG_ID), .SKIP_CNT(SKIP_CNT),
      .TIMEOUT_CNT(TIMEOUT_CNT), .LOST_CNT(LOST_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;
   always @(posedge BUS_CLK) cyc <= cyc + 1;
   always @(negedge BUS_CLK) if (DUT_TRIGGER) trig_seen++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge BUS_CLK);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_rec(input int id, input int ts, input logic [7:0] mask);
      logic [31:0] t;
      logic [15:0] d;
      t = ts;
      d = 16'(id);
      exp_q.push_back(d);
      exp_q.push_back(t[15:0]);
      exp_q.push_back(t[31:16]);
      exp_q.push_back({mask, 8'hA5});
   endtask

   task automatic do_start();
      START = 1'b1;
      s_cyc = cyc;
      tick();
      START = 1'b0;
   endtask

   task automatic pulse_test(output int p);
      TEST_PULSE = 1'b1;
      p = cyc;
      tick();
      TEST_PULSE = 1'b0;
   endtask

   task automatic read_words(input int n);
      rd_req += n;
      for (int i = 0; i < 4 * n + 20 && rd_done < rd_req; i++) tick();
      chk("read_complete", rd_done, rd_req);
      rd_req = rd_done;
      ticks(2);
   endtask

   // monitor: reads one word per cycle while reads are requested
   initial begin
      FIFO_READ = 1'b0;
      forever begin
         @(negedge BUS_CLK);
         if (rd_done < rd_req && !FIFO_EMPTY) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL fifo_word: got %0h with no word expected", FIFO_DATA);
            end else chk("fifo_word", FIFO_DATA, exp_q.pop_front());
            FIFO_READ = 1'b1;
            rd_done++;
         end else FIFO_READ = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p, p2, t0;
      RST = 1'b1; START = 1'b0; CH_IN = '0; CONF_EN = 4'b0011; CONF_INV = '0;
      CONF_MODE = 1'b0; CONF_WINDOW = 5'd4; CONF_TIMEOUT = 16'd0;
      TEST_PULSE = 1'b0; DUT_BUSY = 1'b0;
      ticks(3);
      RST = 1'b0;
      tick();
      chk("rst_empty", FIFO_EMPTY, 1);
      chk("rst_trigger", DUT_TRIGGER, 0);
      chk("rst_id", TRIG_ID, 0);
      chk("rst_skip", SKIP_CNT, 0);
      chk("rst_timeout", TIMEOUT_CNT, 0);
      chk("rst_lost", LOST_CNT, 0);
      // AND, ch1 edge 3 cycles after ch0: inside the window
      do_start();
      ticks(3);
      t0 = trig_seen;
      CH_IN = 4'b0001;
      ticks(3);
      CH_IN = 4'b0011;
      push_rec(0, cyc + 3 - s_cyc, 8'h03);
      ticks(8);
      chk("and_in_window_trig", trig_seen - t0, 1);
      chk("and_in_window_id", TRIG_ID, 1);
      DUT_BUSY = 1'b1;
      ticks(4);
      DUT_BUSY = 1'b0;
      ticks(5);
      read_words(4);
      // AND, ch1 edge 6 cycles after ch0: outside the window
      CH_IN = '0;
      ticks(8);
      do_start();
      ticks(3);
      t0 = trig_seen;
      CH_IN = 4'b0001;
      ticks(6);
      CH_IN = 4'b0011;
      ticks(10);
      chk("and_late_trig", trig_seen - t0, 0);
      chk("and_late_skip", SKIP_CNT, 0);
      chk("and_late_id", TRIG_ID, 0);
      CH_IN = '0;
      ticks(4);
      // busy held: later test pulses are skipped
      do_start();
      DUT_BUSY = 1'b1;
      ticks(4);
      t0 = trig_seen;
      pulse_test(p);
      push_rec(0, p - s_cyc, 8'h00);
      ticks(6);
      pulse_test(p2);
      ticks(6);
      pulse_test(p2);
      ticks(4);
      chk("busy_trigs", trig_seen - t0, 1);
      chk("busy_skip", SKIP_CNT, 2);
      chk("busy_id", TRIG_ID, 1);
      DUT_BUSY = 1'b0;
      ticks(6);
      read_words(4);
      // timeout of 10 cycles with busy never asserted
      CONF_TIMEOUT = 16'd10;
      do_start();
      ticks(2);
      t0 = trig_seen;
      pulse_test(p);
      push_rec(0, p - s_cyc, 8'h00);
      ticks(10);
      chk("tmo_before", TIMEOUT_CNT, 0);
      tick();
      chk("tmo_after", TIMEOUT_CNT, 1);
      pulse_test(p2);
      push_rec(1, p2 - s_cyc, 8'h00);
      ticks(16);
      chk("tmo_trigs", trig_seen - t0, 2);
      chk("tmo_count2", TIMEOUT_CNT, 2);
      chk("tmo_skip", SKIP_CNT, 0);
      read_words(8);
      // overflow: DEPTH+2 records with no reads
      CONF_TIMEOUT = 16'd3;
      do_start();
      ticks(2);
      for (int i = 0; i < DEPTH + 2; i++) begin
         pulse_test(p);
         if (i < DEPTH) push_rec(i, p - s_cyc, 8'h00);
         ticks(8);
      end
      chk("ovf_lost", LOST_CNT, 2);
      chk("ovf_id", TRIG_ID, DEPTH + 2);
      chk("ovf_not_empty", FIFO_EMPTY, 0);
      read_words(4 * DEPTH);
      chk("ovf_drained", FIFO_EMPTY, 1);
      chk("ovf_queue_left", exp_q.size(), 0);
      // reset in the middle of a record readout
      do_start();
      ticks(2);
      pulse_test(p);
      push_rec(0, p - s_cyc, 8'h00);
      ticks(8);
      pulse_test(p);
      push_rec(1, p - s_cyc, 8'h00);
      ticks(8);
      read_words(2);
      RST = 1'b1;
      ticks(2);
      RST = 1'b0;
      s_cyc = cyc - 1;
      exp_q.delete();
      tick();
      chk("midrst_empty", FIFO_EMPTY, 1);
      chk("midrst_id", TRIG_ID, 0);
      chk("midrst_skip", SKIP_CNT, 0);
      chk("midrst_timeout", TIMEOUT_CNT, 0);
      chk("midrst_lost", LOST_CNT, 0);
      pulse_test(p);
      push_rec(0, p - s_cyc, 8'h00);
      ticks(8);
      read_words(4);
      chk("final_empty", FIFO_EMPTY, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
